// File: rtl/wt32_divider_if.sv
// Start/done handshake and operand/result bus of the wt32_divider.
// master: the requester (drives start and operands); slave: the divider.
interface wt32_divider_if #(
   parameter int WIDTH = 32
);
   logic                 start;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 div_by_zero;
   logic                 overflow;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero, overflow
   );
endinterface

// File: rtl/wt32_divider.sv
// Sequential restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, start/done handshake.
// Optional build macro WT32_DIVIDER_FAST_EXIT_EN: when defined, a dividend
// smaller than a non-zero divisor finishes in CHECK (quotient 0) instead of
// running all WIDTH iterations. Numeric results are identical either way.
module wt32_divider #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst,
   wt32_divider_if.slave   bus
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e               state_q,  state_d;
   logic [2*WIDTH-1:0]   dvd_q,    dvd_d;     // dividend shift register; low half collects quotient bits
   logic [WIDTH-1:0]     dsr_q,    dsr_d;     // latched divisor
   logic [WIDTH:0]       prem_q,   prem_d;    // partial remainder
   logic [CNT_W-1:0]     cnt_q,    cnt_d;     // iterations left
   logic [WIDTH-1:0]     quot_q,   quot_d;    // published quotient
   logic [WIDTH-1:0]     rem_q,    rem_d;     // published remainder
   logic                 dz_q,     dz_d;
   logic                 ov_q,     ov_d;

   logic [WIDTH+1:0]     shifted;
   logic [WIDTH+1:0]     diff;
   logic                 qbit;

   // State and datapath registers; every register has a reset value.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the values present before the edge.
      if (rst) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dsr_q   <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dsr_q   <= dsr_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
      end
   end

   // Next-state and datapath: one restoring-division step per RUN cycle.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_d = state_q;
      dvd_d   = dvd_q;
      dsr_d   = dsr_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ov_d    = ov_q;

      // Shift in the next dividend bit (MSB first) and trial-subtract.
      shifted = {prem_q, dvd_q[WIDTH-1]};
      diff    = shifted - {2'b00, dsr_q};
      qbit    = ~diff[WIDTH+1];

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_d   = bus.dividend;
               dsr_d   = bus.divisor;
               dz_d    = 1'b0;
               ov_d    = 1'b0;
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (dsr_q == '0) begin
               dz_d    = 1'b1;
               quot_d  = '1;
               rem_d   = dvd_q[WIDTH-1:0];
               state_d = DONE;
            end else if (dvd_q[2*WIDTH-1:WIDTH] >= dsr_q) begin
               ov_d    = 1'b1;
               quot_d  = '1;
               rem_d   = '0;
               state_d = DONE;
`ifdef WT32_DIVIDER_FAST_EXIT_EN
            end else if ((dvd_q[2*WIDTH-1:WIDTH] == '0) && (dvd_q[WIDTH-1:0] < dsr_q)) begin
               quot_d  = '0;
               rem_d   = dvd_q[WIDTH-1:0];
               state_d = DONE;
`endif
            end else begin
               prem_d  = {1'b0, dvd_q[2*WIDTH-1:WIDTH]};
               cnt_d   = CNT_W'(WIDTH - 1);
               state_d = RUN;
            end
         end

         RUN: begin
            prem_d = qbit ? diff[WIDTH:0] : shifted[WIDTH:0];
            dvd_d  = {dvd_q[2*WIDTH-2:0], qbit};
            if (cnt_q == '0) begin
               quot_d  = dvd_d[WIDTH-1:0];
               rem_d   = prem_d[WIDTH-1:0];
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = (state_q == DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;
   assign bus.overflow    = ov_q;

endmodule

// File: tb/tb_wt32_divider.sv
// Directed self-checking bench for wt32_divider, plus a random round-trip
// sweep (dividend = A*B + R, expecting quotient A and remainder R).
module tb_wt32_divider;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 200;
`ifdef WT32_DIVIDER_FAST_EXIT_EN
   localparam int FAST_LAT = 2;
`else
   localparam int FAST_LAT = 34;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   wt32_divider_if #(.WIDTH(WIDTH)) bus ();

   wt32_divider #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Drive a start pulse; returns #1 after the accepting edge, with the
   // operands scrambled to show the divider works from its latched copies.
   task automatic launch(input logic [63:0] dvd, input logic [31:0] dsr);
      @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dsr;
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = {$urandom, $urandom};
      bus.divisor  = $urandom;
   endtask

   // Wait for done. lat counts cycles from the start edge (1 = cycle just
   // after it); busy_cnt counts sampled cycles with busy high.
   task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
      lat      = lat0;
      busy_cnt = bus.busy ? 1 : 0;
      while (!bus.done && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.busy) busy_cnt++;
      end
      if (!bus.done) check("done_timeout", 64'(lat), 64'(TIMEOUT + 1));
   endtask

   task automatic run_div(input string tag, input logic [63:0] dvd, input logic [31:0] dsr,
                          input int exp_lat, input logic [31:0] exp_q, input logic [31:0] exp_r,
                          input logic exp_dz, input logic exp_ov);
      int lat, bc;
      launch(dvd, dsr);
      wait_done(1, lat, bc);
      check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "_q"},   64'(bus.quotient), 64'(exp_q));
      check({tag, "_r"},   64'(bus.remainder), 64'(exp_r));
      check({tag, "_dz"},  64'(bus.div_by_zero), 64'(exp_dz));
      check({tag, "_ov"},  64'(bus.overflow), 64'(exp_ov));
   endtask

   initial begin
      int lat, bc, dones;
      logic [31:0] a, b, r;

      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_q",    64'(bus.quotient), 64'd0);
      check("rst_r",    64'(bus.remainder), 64'd0);
      check("rst_dz",   64'(bus.div_by_zero), 64'd0);
      check("rst_ov",   64'(bus.overflow), 64'd0);
      rst = 1'b0;

      // Basic divide with busy-length and done-pulse checks.
      launch(64'd42, 32'd7);
      wait_done(1, lat, bc);
      check("basic_lat",  64'(lat), 64'd34);
      check("basic_busy", 64'(bc), 64'd34);
      check("basic_q",    64'(bus.quotient), 64'd6);
      check("basic_r",    64'(bus.remainder), 64'd0);
      check("basic_dz",   64'(bus.div_by_zero), 64'd0);
      check("basic_ov",   64'(bus.overflow), 64'd0);
      @(posedge clk);
      #1;
      check("basic_done_pulse", 64'(bus.done), 64'd0);
      check("basic_idle_busy",  64'(bus.busy), 64'd0);
      check("basic_hold_q",     64'(bus.quotient), 64'd6);

      // Start in the IDLE cycle right after DONE is accepted.
      #0;
      bus.start    = 1'b1;
      bus.dividend = 64'd1000;
      bus.divisor  = 32'd33;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(1, lat, bc);
      check("b2b_lat", 64'(lat), 64'd34);
      check("b2b_q",   64'(bus.quotient), 64'd30);
      check("b2b_r",   64'(bus.remainder), 64'd10);

      run_div("maxprod", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
      run_div("divzero", 64'h0000_0000_1234_5678, 32'd0, 2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0);
      run_div("ovf",     64'h0000_0001_0000_0000, 32'd1, 2, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1);
      run_div("fast",    64'd3, 32'd10, FAST_LAT, 32'd0, 32'd3, 1'b0, 1'b0);
      run_div("big",     64'h0000_0007_FFFF_FFFF, 32'h0000_0010, 34, 32'h7FFF_FFFF, 32'hF, 1'b0, 1'b0);

      // Start while busy is ignored.
      launch(64'd100, 32'd9);
      repeat (9) @(posedge clk);
      #1;
      bus.start    = 1'b1;
      bus.dividend = 64'd5;
      bus.divisor  = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(11, lat, bc);
      check("busyprot_lat", 64'(lat), 64'd34);
      check("busyprot_q",   64'(bus.quotient), 64'd11);
      check("busyprot_r",   64'(bus.remainder), 64'd1);

      // Reset mid-operation abandons the division.
      launch(64'd100, 32'd9);
      repeat (14) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_q",    64'(bus.quotient), 64'd0);
      check("midrst_r",    64'(bus.remainder), 64'd0);
      check("midrst_dz",   64'(bus.div_by_zero), 64'd0);
      check("midrst_ov",   64'(bus.overflow), 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("midrst_no_done", 64'(dones), 64'd0);

      run_div("recover", 64'd100, 32'd9, 34, 32'd11, 32'd1, 1'b0, 1'b0);

      // Random round-trip sweep.
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 4 == 1) b = b >> ($urandom_range(31, 1));
         if (b == 32'd0) b = 32'd1;
         r = $urandom % b;
         launch(64'(a) * 64'(b) + 64'(r), b);
         wait_done(1, lat, bc);
         check("rt_q", 64'(bus.quotient), 64'(a));
         check("rt_r", 64'(bus.remainder), 64'(r));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
